bcd_display_scan: RTL and testbench
===================================

Name: bcd_display_scan

Overview:
- Downstream consumer of the 4-digit BCD up-counter/comparator stage.
- Takes the counter's four BCD digits and its match flag (EQU) and drives a time-multiplexed 4-digit 7-segment display.
- Latches digits tear-free at frame boundaries and blinks the whole display while the match flag is high.

Parameters:
- SCAN_DIV, 50000: clock cycles per digit slot (>=2).
- BLINK_FRAMES, 64: full scan frames per blink half-period (>=1).

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- DIGITS  in  16  BCD digits: [15:12] thousands, [11:8] hundreds, [7:4] tens, [3:0] ones.
- LOAD  in  1  single-cycle strobe; capture DIGITS into the pending register.
- MATCH  in  1  match flag from the counter/comparator (EQU); level-sensitive.
- SEG  out  7  segment drive {g,f,e,d,c,b,a}, active-high.
- AN  out  4  one-hot digit enable, active-high: AN[3] thousands … AN[0] ones.
- FRAME  out  1  one-cycle pulse when a scan frame completes.

Behaviour:
- Reset (async) values:
  - SEG=0, AN=0, FRAME=0.
  - pending=0, shadow=0.
  - prescaler=0, index=0, blink counter=0, blink phase=visible.
- Prescaler:
  - Counts 0..SCAN_DIV-1.
  - tick is asserted when prescaler==SCAN_DIV-1; on tick the prescaler returns to 0.
- Digit index:
  - 2 bits; advances on tick, wrapping 3->0.
  - index 0 = thousands, 3 = ones.
- Frame boundary: tick while index==3. FRAME is registered high for exactly that cycle.
- Load path:
  - LOAD: pending <= DIGITS. Multiple LOADs within one frame: last wins.
  - At frame boundary: shadow <= (LOAD ? DIGITS : pending). A LOAD coinciding with the boundary is displayed in the next frame.
  - The display never mixes digits from two different loads within one frame.
- Decode:
  - 0..9 encode as 3F,06,5B,4F,66,6D,7D,07,7F,6F.
  - Values 10..15 encode as 40 (dash).
- Outputs:
  - Registered; they reflect the current index/shadow with 1-cycle latency.
  - AN is one-hot for index, i.e. AN = 4'b1000 >> index.
  - First rising edge after reset release: AN=1000, SEG=3F.
- Blink:
  - MATCH low: blink counter=0, phase=visible.
  - MATCH high: the counter increments on each frame boundary. On reaching BLINK_FRAMES-1 it clears and the phase toggles.
  - Blank phase: AN=0, SEG=0. Scanning and loading continue unaffected.
- MATCH falling mid-blank: the next cycle forces phase=visible and the counter to 0.
- Reset mid-scan: immediate return to reset values. No partial frame survives.

Optional Feature:
- Macro LEADING_ZERO_BLANK_EN.
- Defined:
  - A digit position of value 0 is blanked (SEG=0, AN still asserted) when it and all higher digits in shadow are 0.
  - The ones digit is never blanked. Example: shadow 0x0050 shows " 50"; 0x0000 shows "0".
  - Invalid digits (>9) count as non-zero.
- Undefined: all four digits are always shown, including leading zeros.

Decomposition:
- Package seg7_pkg:
  - Segment-pattern constants SEG_0..SEG_9 and SEG_DASH.
  - NUM_DIGITS=4.
  - Digit-index typedef (2 bits).
  - Packed BCD-word typedef (16 bits).
- Sub-module bcd_to_seg7: purely combinational 4-bit BCD to 7-segment decoder, instanced once on the selected shadow digit.

Test Plan (SCAN_DIV=4, BLINK_FRAMES=2):
- Reset, then LOAD DIGITS=0x1234 at cycle 2 -> the first frame shows 0000. From the next frame AN sequence 1000,0100,0010,0001 pairs with SEG 06,5B,4F,66, each held 4 cycles; FRAME pulses every 16 cycles.
- LOAD 0x5678 then 0x9012 within one frame -> the next frame shows only 9012 (SEG 6F,3F,06,5B); no frame mixes digits.
- LOAD 0x00AF at exactly a frame-boundary cycle -> the following frame SEG sequence is 3F,3F,40,40.
- MATCH held high after 0x1234 is displayed -> 2 frames visible, 2 frames AN=0/SEG=0, repeating. Drop MATCH during the blank phase -> visible on the next cycle.
- Assert RST mid-frame at index 2 -> AN=0, SEG=0, FRAME=0 immediately. After release, AN=1000 with SEG=3F.
- With LEADING_ZERO_BLANK_EN, LOAD 0x0050 -> thousands and hundreds slots show SEG=00, followed by SEG 6D and 3F. With LOAD 0x0000 only the ones slot shows 3F.

Source files
------------

// File: rtl/seg7_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : seg7_pkg
// Purpose  : Shared 7-segment patterns and BCD display types.
// Revision : 1.0
// ============================================================================
package seg7_pkg;

    localparam int NUM_DIGITS = 4;

    // Segment order {g,f,e,d,c,b,a}, active-high.
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef logic [1:0] digit_idx_t;

    // Element [3] is thousands, element [0] is ones.
    typedef logic [NUM_DIGITS-1:0][3:0] bcd_word_t;

    typedef enum logic [0:0] {
        PHASE_VISIBLE = 1'b0,
        PHASE_BLANK   = 1'b1
    } blink_phase_t;

    // Scan index 0 drives the thousands position, AN[3].
    function automatic logic [3:0] digit_enable(input digit_idx_t idx);
        logic [3:0] an;
        an = 4'b1000;
        return an >> idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_to_seg7.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : bcd_to_seg7
// Purpose  : Combinational BCD to 7-segment decoder; non-BCD codes show a dash.
// Revision : 1.0
// ============================================================================
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_DASH;
        case (bcd_i)
            4'd0: seg_o = SEG_0;
            4'd1: seg_o = SEG_1;
            4'd2: seg_o = SEG_2;
            4'd3: seg_o = SEG_3;
            4'd4: seg_o = SEG_4;
            4'd5: seg_o = SEG_5;
            4'd6: seg_o = SEG_6;
            4'd7: seg_o = SEG_7;
            4'd8: seg_o = SEG_8;
            4'd9: seg_o = SEG_9;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/bcd_display_scan.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : bcd_display_scan
// Purpose  : Tear-free 4-digit multiplexed 7-segment driver with match blink.
//            Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits.
// Revision : 1.0
// ============================================================================
module bcd_display_scan
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] DIGITS,
    input  logic        LOAD,
    input  logic        MATCH,
    output logic [6:0]  SEG,
    output logic [3:0]  AN,
    output logic        FRAME
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    logic [PW-1:0] presc_q, presc_d;
    digit_idx_t    idx_q, idx_d;
    bcd_word_t     pending_q, pending_d;
    bcd_word_t     shadow_q, shadow_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    blink_phase_t  phase_q, phase_d;
    logic [6:0]    seg_q, seg_d;
    logic [3:0]    an_q, an_d;
    logic          frame_q, frame_d;

    logic          tick;
    logic          boundary;
    logic [3:0]    cur_digit;
    logic [6:0]    dec_seg;
    logic          lz_blank;

    // Scan index 0 is thousands, which lives in shadow element 3.
    assign cur_digit = shadow_q[~idx_q];

    bcd_to_seg7 u_dec (
        .bcd_i (cur_digit),
        .seg_o (dec_seg)
    );

    always_comb begin
        lz_blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        case (idx_q)
            2'd0:    lz_blank = (shadow_q[3] == 4'd0);
            2'd1:    lz_blank = (shadow_q[3] == 4'd0) && (shadow_q[2] == 4'd0);
            2'd2:    lz_blank = (shadow_q[3] == 4'd0) && (shadow_q[2] == 4'd0)
                                && (shadow_q[1] == 4'd0);
            default: lz_blank = 1'b0;
        endcase
`else
        lz_blank = 1'b0;
`endif
    end

    always_comb begin
        tick      = (presc_q == PRESC_LAST);
        boundary  = tick && (idx_q == 2'd3);

        presc_d   = tick ? '0 : presc_q + 1'b1;
        idx_d     = tick ? idx_q + 2'd1 : idx_q;
        pending_d = LOAD ? bcd_word_t'(DIGITS) : pending_q;
        shadow_d  = shadow_q;
        // A load landing on the boundary goes straight to the next frame.
        if (boundary) begin
            shadow_d = LOAD ? bcd_word_t'(DIGITS) : pending_q;
        end

        bcnt_d  = bcnt_q;
        phase_d = phase_q;
        if (!MATCH) begin
            bcnt_d  = '0;
            phase_d = PHASE_VISIBLE;
        end else if (boundary) begin
            if (bcnt_q == BLINK_LAST) begin
                bcnt_d  = '0;
                phase_d = (phase_q == PHASE_VISIBLE) ? PHASE_BLANK : PHASE_VISIBLE;
            end else begin
                bcnt_d = bcnt_q + 1'b1;
            end
        end

        frame_d = boundary;
        if (phase_q == PHASE_BLANK) begin
            an_d  = 4'b0000;
            seg_d = SEG_BLANK;
        end else begin
            an_d  = digit_enable(idx_q);
            seg_d = lz_blank ? SEG_BLANK : dec_seg;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            presc_q   <= '0;
            idx_q     <= '0;
            pending_q <= '0;
            shadow_q  <= '0;
            bcnt_q    <= '0;
            phase_q   <= PHASE_VISIBLE;
            seg_q     <= '0;
            an_q      <= '0;
            frame_q   <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
            shadow_q  <= shadow_d;
            bcnt_q    <= bcnt_d;
            phase_q   <= phase_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
            frame_q   <= frame_d;
        end
    end

    assign SEG   = seg_q;
    assign AN    = an_q;
    assign FRAME = frame_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_display_scan.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_bcd_display_scan
// Purpose  : Scoreboard bench for bcd_display_scan (SCAN_DIV=4, BLINK_FRAMES=2).
// Revision : 1.0
// ============================================================================
module tb_bcd_display_scan;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [15:0] DIGITS = '0;
    logic        LOAD = 1'b0;
    logic        MATCH = 1'b0;
    logic [6:0]  SEG;
    logic [3:0]  AN;
    logic        FRAME;

    bcd_display_scan #(
        .SCAN_DIV     (4),
        .BLINK_FRAMES (2)
    ) dut (
        .CLK    (CLK),
        .RST    (RST),
        .DIGITS (DIGITS),
        .LOAD   (LOAD),
        .MATCH  (MATCH),
        .SEG    (SEG),
        .AN     (AN),
        .FRAME  (FRAME)
    );

    always #5 CLK = ~CLK;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] LZ = 7'h00;
`else
    localparam logic [6:0] LZ = 7'h3F;
`endif

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
    } slot_t;

    slot_t exp_q[$];
    int    n;
    int    n_total = 0;
    int    n_pass  = 0;

    // Rising edges since the most recent reset release.
    always @(posedge CLK or posedge RST) begin
        if (RST) n <= 0;
        else     n <= n + 1;
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] want);
        n_total++;
        if (act === want) n_pass++;
        else $display("FAIL %s at cycle %0d: got %h, expected %h", name, n, act, want);
    endtask

    task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3,
                              input bit blank);
        logic [6:0] s [4];
        logic [3:0] a;
        s = '{s0, s1, s2, s3};
        for (int i = 0; i < 4; i++) begin
            a = 4'b1000;
            a = a >> i;
            if (blank) exp_q.push_back('{an: 4'b0000, seg: 7'h00});
            else       exp_q.push_back('{an: a, seg: s[i]});
        end
    endtask

    task automatic push_slot(input logic [3:0] a, input logic [6:0] s);
        exp_q.push_back('{an: a, seg: s});
    endtask

    task automatic wait_n(input int target);
        while (n < target) @(negedge CLK);
    endtask

    // LOAD is high for the edge numbered 'edge_no'.
    task automatic load_at(input int edge_no, input logic [15:0] d);
        wait_n(edge_no - 1);
        LOAD   = 1'b1;
        DIGITS = d;
        @(negedge CLK);
        LOAD   = 1'b0;
    endtask

    // Monitor: slot checked at its first cycle (peek) and last cycle (pop).
    always @(negedge CLK) begin : mon
        slot_t e;
        if (RST) begin
            chk("reset_an",    8'(AN),    8'h00);
            chk("reset_seg",   8'(SEG),   8'h00);
            chk("reset_frame", 8'(FRAME), 8'h00);
        end else if (n >= 1) begin
            chk("frame_pulse", 8'(FRAME), 8'(n % 16 == 0));
            if (exp_q.size() > 0) begin
                if ((n - 1) % 4 == 0) begin
                    e = exp_q[0];
                    chk("slot_start_an",  8'(AN),  8'(e.an));
                    chk("slot_start_seg", 8'(SEG), 8'(e.seg));
                end else if ((n - 1) % 4 == 3) begin
                    e = exp_q.pop_front();
                    chk("slot_end_an",  8'(AN),  8'(e.an));
                    chk("slot_end_seg", 8'(SEG), 8'(e.seg));
                end
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        // Run 1 expectations, frame by frame.
        push_frame(LZ,    LZ,    LZ,    7'h3F, 0);   // f0: shadow 0000
        push_frame(7'h06, 7'h5B, 7'h4F, 7'h66, 0);   // f1: 1234
        push_frame(7'h6F, 7'h3F, 7'h06, 7'h5B, 0);   // f2: 9012 (last load wins)
        push_frame(LZ,    LZ,    7'h40, 7'h40, 0);   // f3: 00AF loaded on boundary
        push_frame(7'h06, 7'h5B, 7'h4F, 7'h66, 0);   // f4: MATCH high, visible
        push_frame(7'h06, 7'h5B, 7'h4F, 7'h66, 0);   // f5
        push_frame(7'h00, 7'h00, 7'h00, 7'h00, 1);   // f6: blank
        push_frame(7'h00, 7'h00, 7'h00, 7'h00, 1);   // f7
        push_frame(7'h06, 7'h5B, 7'h4F, 7'h66, 0);   // f8: visible again
        push_frame(7'h06, 7'h5B, 7'h4F, 7'h66, 0);   // f9
        push_slot(4'b0000, 7'h00);                   // f10: blank until MATCH drops
        push_slot(4'b0000, 7'h00);
        push_slot(4'b0010, 7'h4F);
        push_slot(4'b0001, 7'h66);
        push_frame(7'h06, 7'h5B, 7'h4F, 7'h66, 0);   // f11
        push_slot(4'b1000, 7'h06);                   // f12: reset lands in slot 2
        push_slot(4'b0100, 7'h5B);

        repeat (3) @(negedge CLK);
        RST = 1'b0;

        load_at(2,  16'h1234);
        load_at(20, 16'h5678);
        load_at(24, 16'h9012);
        load_at(48, 16'h00AF);
        load_at(52, 16'h1234);
        wait_n(64);
        MATCH = 1'b1;
        wait_n(167);
        MATCH = 1'b0;

        wait_n(201);
        @(posedge CLK);
        #2 RST = 1'b1;
        repeat (2) @(negedge CLK);
        chk("queue_drained_run1", 8'(exp_q.size()), 8'd0);

        // Run 2 expectations.
        push_frame(LZ, LZ, LZ,    7'h3F, 0);         // f0: first edge AN=1000
        push_frame(LZ, LZ, 7'h6D, 7'h3F, 0);         // f1: 0050
        push_frame(LZ, LZ, LZ,    7'h3F, 0);         // f2: 0000
        RST = 1'b0;

        load_at(2,  16'h0050);
        load_at(20, 16'h0000);
        wait_n(50);
        chk("queue_drained_run2", 8'(exp_q.size()), 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
